// File: rtl/ads5296_link_trainer.sv
// ads5296_link_trainer: automatic word-alignment trainer for the ADS5296x4
// deserialiser. Compares every lane against a test pattern and bitslips
// misaligned lanes in parallel until each locks or exhausts its slips.
// Optional feature macro: ADS5296_LINK_ERRCNT_EN (post-lock error counters).
// Ports:
//   sclk2_in     rising-edge clock for all logic
//   rst_n        asynchronous active-low reset
//   din          10-bit lane words, lane i at [10*i+9:10*i]
//   din_valid    din qualifier
//   pattern      expected test-pattern word
//   train_start  rising edge starts (or restarts) training
//   lane_sel     lane whose error count appears on err_cnt
//   bitslip      per-lane slip request to the deserialiser
//   lane_locked  lane matched a full check window
//   lane_failed  lane exhausted its slip budget
//   train_busy   training in progress
//   train_done   training finished
//   err_cnt      registered error count of lane_sel (0 without the macro)
module ads5296_link_trainer #(
    parameter int G_NUM_LANES     = 16,
    parameter int G_SETTLE_CYCLES = 64,
    parameter int G_CHECK_CYCLES  = 1024,
    parameter int G_MAX_SLIPS     = 10,
    parameter int G_SLIP_HOLD     = 4
) (
    input  logic                           sclk2_in,
    input  logic                           rst_n,
    input  logic [10*G_NUM_LANES-1:0]      din,
    input  logic                           din_valid,
    input  logic [9:0]                     pattern,
    input  logic                           train_start,
    input  logic [$clog2(G_NUM_LANES)-1:0] lane_sel,
    output logic [G_NUM_LANES-1:0]         bitslip,
    output logic [G_NUM_LANES-1:0]         lane_locked,
    output logic [G_NUM_LANES-1:0]         lane_failed,
    output logic                           train_busy,
    output logic                           train_done,
    output logic [15:0]                    err_cnt
);

    localparam int L_MAX0 = (G_SETTLE_CYCLES > G_CHECK_CYCLES) ?
                            G_SETTLE_CYCLES : G_CHECK_CYCLES;
    localparam int L_MAX  = (L_MAX0 > G_SLIP_HOLD) ? L_MAX0 : G_SLIP_HOLD;
    localparam int L_CW   = $clog2(L_MAX + 1);

    localparam logic [L_CW-1:0] L_SETTLE_LAST = L_CW'(G_SETTLE_CYCLES - 1);
    localparam logic [L_CW-1:0] L_CHECK_LAST  = L_CW'(G_CHECK_CYCLES - 1);
    localparam logic [L_CW-1:0] L_HOLD_LAST   = L_CW'(G_SLIP_HOLD - 1);
    localparam logic [3:0]      L_MAX_SLIPS   = 4'(G_MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_EVAL,
        S_SLIP,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [L_CW-1:0]        r_cnt;
    logic                   w_cnt_adv;
    logic                   r_start_q;
    logic                   w_start;
    logic                   w_busy;
    logic                   w_done;
    logic [G_NUM_LANES-1:0] w_mis;
    logic [G_NUM_LANES-1:0] w_slip_req;
    logic [G_NUM_LANES-1:0] r_flag;
    logic [G_NUM_LANES-1:0] r_locked;
    logic [G_NUM_LANES-1:0] r_failed;
    logic [G_NUM_LANES-1:0] r_bitslip;
    logic [3:0]             r_slip_cnt [G_NUM_LANES];

    assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_done  = (r_state == S_DONE);
    // Start edges arriving mid-run are dropped, not queued.
    assign w_start = train_start & ~r_start_q & ~w_busy;

    always_comb begin
        w_mis      = '0;
        w_slip_req = '0;
        for (int i = 0; i < G_NUM_LANES; i++) begin
            w_mis[i]      = (din[10*i +: 10] != pattern);
            w_slip_req[i] = r_flag[i] & ~r_locked[i] & ~r_failed[i] &
                            (r_slip_cnt[i] < L_MAX_SLIPS);
        end
    end

    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_adv   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                w_cnt_adv = din_valid;
                if (din_valid && r_cnt == L_SETTLE_LAST)
                    w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_cnt_adv = din_valid;
                if (din_valid && r_cnt == L_CHECK_LAST)
                    w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_state_nxt = (|w_slip_req) ? S_SLIP : S_DONE;
            end
            S_SLIP: begin
                w_cnt_adv = 1'b1;
                if (r_cnt == L_HOLD_LAST) w_state_nxt = S_SETTLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One shared counter: restarts on every state change.
    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= train_start;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_adv) begin
                r_cnt <= r_cnt + L_CW'(1);
            end
        end
    end

    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
        end else if (r_state != S_SETTLE && w_state_nxt == S_SETTLE) begin
            r_flag <= '0;
        end else if (r_state == S_CHECK && din_valid) begin
            r_flag <= r_flag | w_mis;
        end
    end

    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= '0;
            r_failed <= '0;
            for (int i = 0; i < G_NUM_LANES; i++) r_slip_cnt[i] <= 4'd0;
        end else if (w_start) begin
            r_locked <= '0;
            r_failed <= '0;
            for (int i = 0; i < G_NUM_LANES; i++) r_slip_cnt[i] <= 4'd0;
        end else if (r_state == S_EVAL) begin
            for (int i = 0; i < G_NUM_LANES; i++) begin
                if (!r_locked[i] && !r_failed[i]) begin
                    if (!r_flag[i]) begin
                        r_locked[i] <= 1'b1;
                    end else if (w_slip_req[i]) begin
                        r_slip_cnt[i] <= r_slip_cnt[i] + 4'd1;
                    end else begin
                        r_failed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Slip mask captured leaving EVAL, held for the whole SLIP state.
    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            r_bitslip <= '0;
        end else if (r_state == S_EVAL && w_state_nxt == S_SLIP) begin
            r_bitslip <= w_slip_req;
        end else if (w_state_nxt != S_SLIP) begin
            r_bitslip <= '0;
        end
    end

`ifdef ADS5296_LINK_ERRCNT_EN
    logic [15:0] r_errc [G_NUM_LANES];
    logic [15:0] r_err_cnt;

    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G_NUM_LANES; i++) r_errc[i] <= 16'h0000;
        end else if (w_start) begin
            for (int i = 0; i < G_NUM_LANES; i++) r_errc[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < G_NUM_LANES; i++) begin
                if (w_done && r_locked[i] && din_valid && w_mis[i] &&
                    r_errc[i] != 16'hFFFF) begin
                    r_errc[i] <= r_errc[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge sclk2_in or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 16'h0000;
        end else if (int'(lane_sel) < G_NUM_LANES) begin
            r_err_cnt <= r_errc[lane_sel];
        end else begin
            r_err_cnt <= 16'h0000;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_sel;
    assign w_unused_sel = ^lane_sel;
    assign err_cnt      = 16'h0000;
`endif

    assign bitslip     = r_bitslip;
    assign lane_locked = r_locked;
    assign lane_failed = r_failed;
    assign train_busy  = w_busy;
    assign train_done  = w_done;

endmodule

// File: tb/tb_ads5296_link_trainer.sv
// tb_ads5296_link_trainer: directed bench for ads5296_link_trainer with a
// behavioural deserialiser model that rotates lanes on each bitslip pulse.
module tb_ads5296_link_trainer;

    logic         clk;
    logic         rst_n;
    logic [159:0] din;
    logic         din_valid;
    logic [9:0]   pattern;
    logic         train_start;
    logic [3:0]   lane_sel;
    logic [15:0]  bitslip;
    logic [15:0]  lane_locked;
    logic [15:0]  lane_failed;
    logic         train_busy;
    logic         train_done;
    logic [15:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Deserialiser model state
    int          base_off [16];
    int          pulses   [16];
    int          highs    [16];
    logic [15:0] zero_lane;
    logic [15:0] inj;
    logic [15:0] bs_q;
    logic [19:0] rw [16];

    ads5296_link_trainer dut (
        .sclk2_in    (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .pattern     (pattern),
        .train_start (train_start),
        .lane_sel    (lane_sel),
        .bitslip     (bitslip),
        .lane_locked (lane_locked),
        .lane_failed (lane_failed),
        .train_busy  (train_busy),
        .train_done  (train_done),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each bitslip pulse moves the lane one bit closer to alignment.
    initial bs_q = '0;
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (bitslip[i] && !bs_q[i]) pulses[i] = pulses[i] + 1;
            if (bitslip[i]) highs[i] = highs[i] + 1;
        end
        bs_q = bitslip;
    end

    always_comb begin
        din = '0;
        for (int i = 0; i < 16; i++) begin
            rw[i] = '0;
            rw[i] = {pattern, pattern} <<
                    ((base_off[i] + 10 - (pulses[i] % 10)) % 10);
            din[10*i +: 10] = zero_lane[i] ? 10'h000 :
                              (rw[i][19:10] ^ {10{inj[i]}});
        end
    end

    task automatic set_off(input int lane, input int k);
        base_off[lane] = (k + pulses[lane]) % 10;
    endtask

    task automatic run_train(input int limit, input bit half,
                             input int restart_at,
                             output int n, output logic busy_mid);
        n = 0;
        busy_mid = 1'b0;
        train_start = 1'b1;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) busy_mid = train_busy;
            if (restart_at != 0 && n == restart_at) train_start = 1'b0;
            if (restart_at != 0 && n == restart_at + 2) train_start = 1'b1;
            if (half) din_valid = ~din_valid;
            if (train_done) break;
        end
        train_start = 1'b0;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din_valid = 1'b1;
        pattern = 10'h2A5;
        train_start = 1'b0;
        lane_sel = 4'd0;
        zero_lane = '0;
        inj = '0;
        for (int i = 0; i < 16; i++) base_off[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bitslip !== 16'h0) begin
            n_bad++; $display("FAIL rst_bitslip: got %h want 0", bitslip);
        end
        n_cmp++;
        if (lane_locked !== 16'h0) begin
            n_bad++; $display("FAIL rst_locked: got %h want 0", lane_locked);
        end
        n_cmp++;
        if (lane_failed !== 16'h0) begin
            n_bad++; $display("FAIL rst_failed: got %h want 0", lane_failed);
        end
        n_cmp++;
        if (train_busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_busy: got %b want 0", train_busy);
        end
        n_cmp++;
        if (train_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_done: got %b want 0", train_done);
        end
        n_cmp++;
        if (err_cnt !== 16'h0) begin
            n_bad++; $display("FAIL rst_errcnt: got %h want 0", err_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_all_aligned();
        int   n;
        logic bm;
        int   p0 [16];
        for (int i = 0; i < 16; i++) p0[i] = pulses[i];
        run_train(2000, 1'b0, 0, n, bm);
        n_cmp++;
        if (n !== 1090) begin
            n_bad++; $display("FAIL aligned_cycles: got %0d want 1090", n);
        end
        n_cmp++;
        if (bm !== 1'b1) begin
            n_bad++; $display("FAIL aligned_busy_mid: got %b want 1", bm);
        end
        n_cmp++;
        if (lane_locked !== 16'hFFFF) begin
            n_bad++; $display("FAIL aligned_locked: got %h want ffff", lane_locked);
        end
        n_cmp++;
        if (lane_failed !== 16'h0) begin
            n_bad++; $display("FAIL aligned_failed: got %h want 0", lane_failed);
        end
        n_cmp++;
        if (train_done !== 1'b1 || train_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL aligned_status: got done=%b busy=%b want 1/0",
                     train_done, train_busy);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (pulses[i] - p0[i] !== 0) begin
                n_bad++;
                $display("FAIL aligned_slips lane %0d: got %0d want 0",
                         i, pulses[i] - p0[i]);
            end
        end
    endtask

    task automatic test_lane3_rotated();
        int   n;
        logic bm;
        int   p0 [16];
        int   h0 [16];
        for (int i = 0; i < 16; i++) begin
            p0[i] = pulses[i];
            h0[i] = highs[i];
        end
        set_off(3, 3);
        run_train(6000, 1'b0, 0, n, bm);
        n_cmp++;
        if (n !== 4369) begin
            n_bad++; $display("FAIL rot3_cycles: got %0d want 4369", n);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (pulses[i] - p0[i] !== ((i == 3) ? 3 : 0)) begin
                n_bad++;
                $display("FAIL rot3_pulses lane %0d: got %0d want %0d",
                         i, pulses[i] - p0[i], (i == 3) ? 3 : 0);
            end
        end
        n_cmp++;
        if (highs[3] - h0[3] !== 12) begin
            n_bad++;
            $display("FAIL rot3_hold: got %0d want 12", highs[3] - h0[3]);
        end
        n_cmp++;
        if (lane_locked !== 16'hFFFF || lane_failed !== 16'h0) begin
            n_bad++;
            $display("FAIL rot3_result: got lk=%h fl=%h want ffff/0",
                     lane_locked, lane_failed);
        end
        n_cmp++;
        if (train_done !== 1'b1) begin
            n_bad++; $display("FAIL rot3_done: got %b want 1", train_done);
        end
    endtask

    task automatic test_lane5_dead();
        int   n;
        logic bm;
        int   p0 [16];
        int   h0 [16];
        for (int i = 0; i < 16; i++) begin
            p0[i] = pulses[i];
            h0[i] = highs[i];
        end
        zero_lane = 16'h0020;
        run_train(14000, 1'b0, 0, n, bm);
        n_cmp++;
        if (n !== 12020) begin
            n_bad++; $display("FAIL dead5_cycles: got %0d want 12020", n);
        end
        n_cmp++;
        if (pulses[5] - p0[5] !== 10) begin
            n_bad++;
            $display("FAIL dead5_pulses: got %0d want 10", pulses[5] - p0[5]);
        end
        n_cmp++;
        if (highs[5] - h0[5] !== 40) begin
            n_bad++;
            $display("FAIL dead5_hold: got %0d want 40", highs[5] - h0[5]);
        end
        n_cmp++;
        if (pulses[4] - p0[4] !== 0) begin
            n_bad++;
            $display("FAIL dead5_other: got %0d want 0", pulses[4] - p0[4]);
        end
        n_cmp++;
        if (lane_failed !== 16'h0020) begin
            n_bad++; $display("FAIL dead5_failed: got %h want 0020", lane_failed);
        end
        n_cmp++;
        if (lane_locked !== 16'hFFDF) begin
            n_bad++; $display("FAIL dead5_locked: got %h want ffdf", lane_locked);
        end
        n_cmp++;
        if (train_done !== 1'b1) begin
            n_bad++; $display("FAIL dead5_done: got %b want 1", train_done);
        end
        zero_lane = '0;
    endtask

    task automatic test_half_valid();
        int   n;
        logic bm;
        run_train(3000, 1'b1, 600, n, bm);
        n_cmp++;
        if (n < 2177 || n > 2178) begin
            n_bad++; $display("FAIL half_cycles: got %0d want 2177..2178", n);
        end
        n_cmp++;
        if (lane_locked !== 16'hFFFF || lane_failed !== 16'h0) begin
            n_bad++;
            $display("FAIL half_result: got lk=%h fl=%h want ffff/0",
                     lane_locked, lane_failed);
        end
        n_cmp++;
        if (train_done !== 1'b1) begin
            n_bad++; $display("FAIL half_done: got %b want 1", train_done);
        end
    endtask

    task automatic test_reset_in_slip();
        int   n;
        int   w;
        logic bm;
        set_off(3, 2);
        train_start = 1'b1;
        w = 0;
        while (w < 3000) begin
            @(posedge clk);
            #1;
            w++;
            if (bitslip[3]) break;
        end
        n_cmp++;
        if (bitslip[3] !== 1'b1) begin
            n_bad++; $display("FAIL rs_slip_seen: got %b want 1", bitslip[3]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bitslip !== 16'h0) begin
            n_bad++; $display("FAIL rs_bitslip: got %h want 0", bitslip);
        end
        n_cmp++;
        if (lane_locked !== 16'h0 || lane_failed !== 16'h0) begin
            n_bad++;
            $display("FAIL rs_lanes: got lk=%h fl=%h want 0/0",
                     lane_locked, lane_failed);
        end
        n_cmp++;
        if (train_busy !== 1'b0 || train_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rs_status: got busy=%b done=%b want 0/0",
                     train_busy, train_done);
        end
        train_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_train(5000, 1'b0, 0, n, bm);
        n_cmp++;
        if (n !== 3276) begin
            n_bad++; $display("FAIL rs_retrain_cycles: got %0d want 3276", n);
        end
        n_cmp++;
        if (lane_locked !== 16'hFFFF || train_done !== 1'b1) begin
            n_bad++;
            $display("FAIL rs_retrain: got lk=%h done=%b want ffff/1",
                     lane_locked, train_done);
        end
    endtask

    task automatic test_errcnt();
        logic [15:0] exp_e;
`ifdef ADS5296_LINK_ERRCNT_EN
        exp_e = 16'd5;
`else
        exp_e = 16'd0;
`endif
        lane_sel = 4'd2;
        inj = 16'h0004;
        repeat (5) @(posedge clk);
        #1;
        inj = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== exp_e) begin
            n_bad++; $display("FAIL errcnt_lane2: got %0d want %0d", err_cnt, exp_e);
        end
        lane_sel = 4'd3;
        @(posedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_bad++; $display("FAIL errcnt_lane3: got %0d want 0", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_all_aligned();
        test_lane3_rotated();
        test_lane5_dead();
        test_half_valid();
        test_reset_in_slip();
        test_errcnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
